// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;
  typedef enum logic {OwnIf, OwnMem} owner_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam logic Busy    = 1'b1;
  localparam logic NotBusy = 1'b0;

  // Lengths above a word are treated as a word.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > LEN_W) ? LEN_W : len;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request, completion and RAM-port signals of the memory controller.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              IF_req_in;
  logic [31:0]       IF_addr_in;
  logic              MEM_req_in;
  logic              MEM_rw_in;
  logic [31:0]       MEM_addr_in;
  logic [31:0]       MEM_data_in;
  logic [2:0]        MEM_len_in;
  logic [7:0]        ram_data_in;
  logic              busyIF_out;
  logic              busyMEM_out;
  logic              IF_dataE_out;
  logic              MEM_dataE_out;
  logic [31:0]       data_out;
  logic              ram_rw_out;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [7:0]        ram_data_out;

  modport master (
    output IF_req_in, IF_addr_in, MEM_req_in, MEM_rw_in, MEM_addr_in, MEM_data_in, MEM_len_in,
           ram_data_in,
    input  busyIF_out, busyMEM_out, IF_dataE_out, MEM_dataE_out, data_out, ram_rw_out,
           ram_addr_out, ram_data_out
  );

  modport slave (
    input  IF_req_in, IF_addr_in, MEM_req_in, MEM_rw_in, MEM_addr_in, MEM_data_in, MEM_len_in,
           ram_data_in,
    output busyIF_out, busyMEM_out, IF_dataE_out, MEM_dataE_out, data_out, ram_rw_out,
           ram_addr_out, ram_data_out
  );
endinterface

// File: rtl/mc_byte_seq.sv
// Byte sequencer: issues addr+k accesses, extracts write lanes, assembles read lanes.
module mc_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic              rw,
  input  logic [2:0]        len,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [7:0]        ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_rw,
  output logic [31:0]       rdata,
  output logic              last,
  output logic              done
);

  logic              active_q, active_d;
  logic              rw_q, rw_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              ram_rw_q, ram_rw_d;
  logic [2:0]        step;
  logic [1:0]        wr_lane;
  logic [1:0]        rd_lane;

  // cyc_q counts edges since acceptance; the last issued byte is on the bus when cyc_q == len-1.
  assign last  = active_q && (cyc_q == len_q - 3'd1);
  assign done  = active_q && (rw_q == READ) && (cyc_q == len_q);
  assign rdata = asm_d;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_rw    = ram_rw_q;

  always_comb begin
    step        = cyc_q + 3'd1;
    wr_lane     = step[1:0];
    rd_lane     = 2'(step - 3'd2);
    active_d    = active_q;
    rw_d        = rw_q;
    len_d       = len_q;
    cyc_d       = cyc_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ram_rw_d    = 1'b0;
    if (start) begin
      active_d = (len != 3'd0);
      rw_d     = rw;
      len_d    = len;
      cyc_d    = 3'd0;
      base_d   = addr;
      wdata_d  = wdata;
      asm_d    = '0;
      if (len != 3'd0) begin
        ram_addr_d  = addr;
        ram_wdata_d = wdata[7:0];
        ram_rw_d    = rw;
      end
    end else if (active_q) begin
      cyc_d = step;
      if (step < len_q) begin
        ram_addr_d  = base_q + ADDR_W'(step);
        ram_wdata_d = wdata_q[{wr_lane, 3'b000} +: 8];
        ram_rw_d    = rw_q;
      end
      // RAM answers one cycle after the address, so byte k lands two edges after issue.
      if (rw_q == READ && step >= 3'd2) begin
        asm_d[{rd_lane, 3'b000} +: 8] = ram_rdata;
      end
      if (done || (rw_q == WRITE && last)) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_q    <= 1'b0;
      rw_q        <= READ;
      len_q       <= 3'd0;
      cyc_q       <= 3'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_rw_q    <= 1'b0;
    end else begin
      active_q    <= active_d;
      rw_q        <= rw_d;
      len_q       <= len_d;
      cyc_q       <= cyc_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_rw_q    <= ram_rw_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the MEM stage.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic       clk_in,
  input logic       rst_in,
  mem_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        busy_if_q, busy_if_d;
  logic        busy_mem_q, busy_mem_d;
  logic        if_de_q, if_de_d;
  logic        mem_de_q, mem_de_d;
  logic [31:0] data_q, data_d;

  logic        start;
  logic        req_rw;
  logic [2:0]  req_len;
  logic [31:0] req_addr;
  logic [31:0] seq_rdata;
  logic        seq_last;
  logic        seq_done;

  mc_byte_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (start),
    .rw        (req_rw),
    .len       (req_len),
    .addr      (ADDR_W'(req_addr)),
    .wdata     (bus.MEM_data_in),
    .ram_rdata (bus.ram_data_in),
    .ram_addr  (bus.ram_addr_out),
    .ram_wdata (bus.ram_data_out),
    .ram_rw    (bus.ram_rw_out),
    .rdata     (seq_rdata),
    .last      (seq_last),
    .done      (seq_done)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      busy_if_q  <= NotBusy;
      busy_mem_q <= NotBusy;
      if_de_q    <= 1'b0;
      mem_de_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      busy_if_q  <= busy_if_d;
      busy_mem_q <= busy_mem_d;
      if_de_q    <= if_de_d;
      mem_de_q   <= mem_de_d;
      data_q     <= data_d;
    end
  end

  // The DONE cycle doubles as an acceptance point; its owner has already dropped its request.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    start    = 1'b0;
    req_rw   = READ;
    req_len  = LEN_W;
    req_addr = bus.IF_addr_in;
    if (bus.MEM_req_in) begin
      req_rw   = bus.MEM_rw_in;
      req_len  = clamp_len(bus.MEM_len_in);
      req_addr = bus.MEM_addr_in;
    end
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.MEM_req_in || bus.IF_req_in) begin
          start   = 1'b1;
          owner_d = bus.MEM_req_in ? OwnMem : OwnIf;
          if (req_len == 3'd0) begin
            state_d = StDone;
          end else begin
            state_d = (req_rw == WRITE) ? StWr : StRd;
          end
        end
      end
      StRd: if (seq_done) state_d = StDone;
      StWr: if (seq_last) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_if_d  = NotBusy;
    busy_mem_d = NotBusy;
    if_de_d    = 1'b0;
    mem_de_d   = 1'b0;
    data_d     = '0;
    if (state_d != StIdle) begin
      if (owner_d == OwnIf) busy_if_d = Busy;
      else                  busy_mem_d = Busy;
    end
    if (state_d == StDone) begin
      if_de_d  = (owner_d == OwnIf);
      mem_de_d = (owner_d == OwnMem);
      data_d   = seq_rdata;
    end
  end

  assign bus.busyIF_out    = busy_if_q;
  assign bus.busyMEM_out   = busy_mem_q;
  assign bus.IF_dataE_out  = if_de_q;
  assign bus.MEM_dataE_out = mem_de_q;
  assign bus.data_out      = data_q;

endmodule
